uart_tx_module: RTL and testbench

UART_TX_MODULE -- requirements
Module: uart_tx_module

---
 rtl/uart_tx_module.sv | 151 +++++++++++++++
 tb/tb_uart_tx_module.sv | 287 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_module.sv
// UART transmitter: 8 data bits LSB first, optional odd/even parity, 1 or 2 stop bits.
// Every output comes straight from a flop so the line never glitches.
module uart_tx_module #(
    parameter int unsigned CLK_HZ    = 49152000,
    parameter int unsigned BAUD      = 9600,
    parameter int unsigned PARITY    = 0,
    parameter int unsigned STOP_BITS = 1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       Tx_En_Sig,
    input  logic [7:0] TxData,
    output logic       TXD,
    output logic       Tx_Busy,
    output logic       Tx_Done_Sig
);

    localparam int unsigned BIT_CYCLES = CLK_HZ / BAUD;
    localparam int unsigned CNT_W      = (BIT_CYCLES > 2) ? $clog2(BIT_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BIT_CYCLES - 1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_START = 3'd1,
        S_DATA  = 3'd2,
        S_PAR   = 3'd3,
        S_STOP  = 3'd4
    } state_e;

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2:0]       idx_q, idx_d;
    logic             stop_q, stop_d;
    logic [7:0]       data_q, data_d;
    logic             txd_q, txd_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             bit_end_c;
    logic             par_bit_c;

    // Last clock of the current bit period
    assign bit_end_c = (cnt_q == CNT_LAST);

    // Odd parity inverts the even (XOR) parity of the latched byte
    assign par_bit_c = (PARITY == 1) ? ~(^data_q) : (^data_q);

    // State and output registers; reset aborts any frame and parks the line high
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            idx_q   <= '0;
            stop_q  <= 1'b0;
            data_q  <= '0;
            txd_q   <= 1'b1;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            stop_q  <= stop_d;
            data_q  <= data_d;
            txd_q   <= txd_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    // Next-state and next-output logic; the registered TXD value is the bit being sent
    always_comb begin
        state_d = state_q;
        cnt_d   = bit_end_c ? '0 : cnt_q + CNT_W'(1);
        idx_d   = idx_q;
        stop_d  = stop_q;
        data_d  = data_q;
        txd_d   = txd_q;
        busy_d  = busy_q;
        done_d  = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                cnt_d  = '0;
                txd_d  = 1'b1;
                busy_d = 1'b0;
                if (Tx_En_Sig) begin
                    data_d  = TxData;
                    state_d = S_START;
                    txd_d   = 1'b0;
                    busy_d  = 1'b1;
                end
            end
            S_START: begin
                if (bit_end_c) begin
                    state_d = S_DATA;
                    idx_d   = '0;
                    txd_d   = data_q[0];
                end
            end
            S_DATA: begin
                if (bit_end_c) begin
                    if (idx_q == 3'd7) begin
                        idx_d  = '0;
                        stop_d = 1'b0;
                        if (PARITY != 0) begin
                            state_d = S_PAR;
                            txd_d   = par_bit_c;
                        end else begin
                            state_d = S_STOP;
                            txd_d   = 1'b1;
                        end
                    end else begin
                        idx_d = idx_q + 3'd1;
                        txd_d = data_q[idx_q + 3'd1];
                    end
                end
            end
            S_PAR: begin
                if (bit_end_c) begin
                    state_d = S_STOP;
                    stop_d  = 1'b0;
                    txd_d   = 1'b1;
                end
            end
            S_STOP: begin
                txd_d = 1'b1;
                if (bit_end_c) begin
                    if ((STOP_BITS == 2) && !stop_q) begin
                        stop_d = 1'b1;
                    end else begin
                        state_d = S_IDLE;
                        stop_d  = 1'b0;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
                cnt_d   = '0;
                txd_d   = 1'b1;
                busy_d  = 1'b0;
            end
        endcase
    end

    assign TXD         = txd_q;
    assign Tx_Busy     = busy_q;
    assign Tx_Done_Sig = done_q;

endmodule

// File: tb/tb_uart_tx_module.sv
// Bench for uart_tx_module: four instances cover no parity, even, odd and two stop bits.
// Stimulus queues expected frames; a per-instance monitor decodes the line and compares.
module tb_uart_tx_module;

    localparam int BC = 16;

    typedef struct {
        int         cfg;
        logic [7:0] data;
        bit         has_par;
        logic       par_bit;
        int         nstop;
        int         len;
        bit         abort;
    } frame_t;

    logic       clk = 1'b0;
    logic [3:0] rst_n;
    logic [3:0] en;
    logic [7:0] din [4];
    logic [3:0] txd;
    logic [3:0] busy;
    logic [3:0] done;

    int     n_cmp = 0;
    int     n_bad = 0;
    int     idle_low [4];
    frame_t sb_q[$];

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, required 0x%0h", name, got, exp);
        end
    endtask

    task automatic push_frame(input int g, input logic [7:0] d, input bit hp, input logic pb,
                              input int ns, input int len, input bit ab);
        frame_t e;
        e.cfg     = g;
        e.data    = d;
        e.has_par = hp;
        e.par_bit = pb;
        e.nstop   = ns;
        e.len     = len;
        e.abort   = ab;
        sb_q.push_back(e);
    endtask

    for (genvar g = 0; g < 4; g++) begin : g_dut
        localparam int unsigned PAR = (g == 1) ? 2 : ((g == 2) ? 1 : 0);
        localparam int unsigned STP = (g == 3) ? 2 : 1;

        uart_tx_module #(
            .CLK_HZ   (1600),
            .BAUD     (100),
            .PARITY   (PAR),
            .STOP_BITS(STP)
        ) u_dut (
            .clk        (clk),
            .reset      (rst_n[g]),
            .Tx_En_Sig  (en[g]),
            .TxData     (din[g]),
            .TXD        (txd[g]),
            .Tx_Busy    (busy[g]),
            .Tx_Done_Sig(done[g])
        );

        // Line monitor: records TXD each clock of a frame, decodes it at Tx_Done_Sig
        initial begin : mon
            int          t;
            int          nb;
            int          n;
            int          unstable;
            bit          in_frame;
            bit          chk_low;
            logic        mid;
            logic        line[$];
            logic [15:0] got_bits;
            logic [15:0] exp_bits;
            frame_t      e;
            in_frame    = 1'b0;
            chk_low     = 1'b0;
            t           = 0;
            idle_low[g] = 0;
            forever begin
                @(posedge clk);
                #1;
                if (chk_low) begin
                    check("done_one_clock", 32'(done[g]), 32'(0));
                    chk_low = 1'b0;
                end
                if (in_frame) begin
                    t++;
                    if (done[g]) begin
                        in_frame = 1'b0;
                        chk_low  = 1'b1;
                        if (sb_q.size() == 0) begin
                            n_cmp++;
                            n_bad++;
                            $display("FAIL unexpected_frame: instance %0d sent a frame, none queued", g);
                        end else begin
                            e = sb_q.pop_front();
                            check("cfg", 32'(g), 32'(e.cfg));
                            check("abort_expected", 32'(0), 32'(e.abort));
                            check("frame_len", 32'(t), 32'(e.len));
                            check("txd_at_done", 32'(txd[g]), 32'(1));
                            exp_bits = '0;
                            n = 1;
                            for (int i = 0; i < 8; i++) begin
                                exp_bits[n] = e.data[i];
                                n++;
                            end
                            if (e.has_par) begin
                                exp_bits[n] = e.par_bit;
                                n++;
                            end
                            for (int i = 0; i < e.nstop; i++) begin
                                exp_bits[n] = 1'b1;
                                n++;
                            end
                            got_bits = '0;
                            unstable = 0;
                            nb = t / BC;
                            for (int j = 0; j < nb && j < 16; j++) begin
                                mid = line[j * BC + BC / 2];
                                got_bits[j] = mid;
                                for (int k = 0; k < BC; k++)
                                    if (line[j * BC + k] !== mid) unstable++;
                            end
                            check("line_bits", 32'(got_bits), 32'(exp_bits));
                            check("data_byte", 32'(got_bits[8:1]), 32'(e.data));
                            check("bit_stable", 32'(unstable), 32'(0));
                        end
                    end else if (!busy[g]) begin
                        in_frame = 1'b0;
                        if (sb_q.size() == 0) begin
                            n_cmp++;
                            n_bad++;
                            $display("FAIL unexpected_abort: instance %0d dropped busy, none queued", g);
                        end else begin
                            e = sb_q.pop_front();
                            check("abort_expected", 32'(1), 32'(e.abort));
                            check("abort_txd", 32'(txd[g]), 32'(1));
                        end
                    end else begin
                        line.push_back(txd[g]);
                    end
                end else if (busy[g]) begin
                    in_frame = 1'b1;
                    t = 0;
                    line.delete();
                    line.push_back(txd[g]);
                end else if (rst_n[g] && (txd[g] !== 1'b1 || done[g] === 1'b1)) begin
                    idle_low[g]++;
                end
            end
        end
    end

    task automatic wait_done(input int g, input string name);
        int k;
        for (k = 0; k < 400; k++) begin
            @(posedge clk);
            #2;
            if (done[g]) break;
        end
        check(name, 32'(k < 400), 32'(1));
    endtask

    // Single request pulse; a stray request and data change mid-frame must be ignored
    task automatic send(input int g, input logic [7:0] d, input bit hp, input logic pb,
                        input int ns, input int len);
        push_frame(g, d, hp, pb, ns, len, 1'b0);
        din[g] = d;
        en[g]  = 1'b1;
        @(posedge clk);
        #2;
        en[g]  = 1'b0;
        din[g] = ~d;
        repeat (40) @(posedge clk);
        #2;
        en[g] = 1'b1;
        @(posedge clk);
        #2;
        en[g] = 1'b0;
        wait_done(g, "send_done_seen");
        repeat (3) @(posedge clk);
        #2;
    endtask

    initial begin
        rst_n = '1;
        en    = '0;
        for (int i = 0; i < 4; i++) din[i] = 8'h00;
        #2;
        rst_n = '0;
        #1;
        for (int i = 0; i < 4; i++) begin
            check("rst_txd", 32'(txd[i]), 32'(1));
            check("rst_busy", 32'(busy[i]), 32'(0));
            check("rst_done", 32'(done[i]), 32'(0));
        end
        repeat (3) @(posedge clk);
        #2;
        rst_n = '1;
        @(posedge clk);
        #2;

        // No parity, one stop bit
        send(0, 8'h55, 1'b0, 1'b0, 1, 160);

        // Back-to-back with request held high and data changed mid-frame
        push_frame(0, 8'h5A, 1'b0, 1'b0, 1, 160, 1'b0);
        push_frame(0, 8'hA3, 1'b0, 1'b0, 1, 160, 1'b0);
        din[0] = 8'h5A;
        en[0]  = 1'b1;
        @(posedge clk);
        #2;
        repeat (30) @(posedge clk);
        #2;
        din[0] = 8'hA3;
        wait_done(0, "b2b_first_done_seen");
        check("b2b_gap_txd_high", 32'(txd[0]), 32'(1));
        @(posedge clk);
        #2;
        check("b2b_restart_busy", 32'(busy[0]), 32'(1));
        check("b2b_restart_txd", 32'(txd[0]), 32'(0));
        en[0] = 1'b0;
        wait_done(0, "b2b_second_done_seen");
        repeat (3) @(posedge clk);
        #2;

        // Reset during data bit 2 (clock 50), then a clean frame
        push_frame(0, 8'hC3, 1'b0, 1'b0, 1, 0, 1'b1);
        din[0] = 8'hC3;
        en[0]  = 1'b1;
        @(posedge clk);
        #2;
        en[0] = 1'b0;
        repeat (49) @(posedge clk);
        #3;
        check("pre_reset_txd", 32'(txd[0]), 32'(0));
        check("pre_reset_busy", 32'(busy[0]), 32'(1));
        rst_n[0] = 1'b0;
        #1;
        check("async_rst_txd", 32'(txd[0]), 32'(1));
        check("async_rst_busy", 32'(busy[0]), 32'(0));
        check("async_rst_done", 32'(done[0]), 32'(0));
        repeat (3) @(posedge clk);
        #2;
        check("rst_hold_done", 32'(done[0]), 32'(0));
        rst_n[0] = 1'b1;
        @(posedge clk);
        #2;
        send(0, 8'h33, 1'b0, 1'b0, 1, 160);

        // Even parity
        send(1, 8'h07, 1'b1, 1'b1, 1, 176);
        send(1, 8'h00, 1'b1, 1'b0, 1, 176);

        // Odd parity
        send(2, 8'h07, 1'b1, 1'b0, 1, 176);
        send(2, 8'hFF, 1'b1, 1'b1, 1, 176);

        // Two stop bits
        send(3, 8'h00, 1'b0, 1'b0, 2, 176);
        send(3, 8'h81, 1'b0, 1'b0, 2, 176);

        repeat (5) @(posedge clk);
        #2;
        check("scoreboard_drained", 32'(sb_q.size()), 32'(0));
        for (int i = 0; i < 4; i++) check("idle_line_high", 32'(idle_low[i]), 32'(0));
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, got no finish, required finish");
        $fatal(1);
    end

endmodule
